exec_issue_ctrl: RTL and testbench

EXEC_ISSUE_CTRL -- requirements
Module: exec_issue_ctrl

---
 rtl/exec_issue_ctrl_pkg.sv | 42 ++++
 rtl/exec_issue_ctrl_if.sv | 34 +++
 rtl/exec_issue_ctrl_scoreboard.sv | 49 ++++
 rtl/exec_issue_ctrl.sv | 124 ++++++++++++
 tb/tb_exec_issue_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_issue_ctrl_pkg.sv
// Shared definitions for the execute issue controller: FSM state encoding,
// one-hot instruction-type bit positions, register-index width, and the
// operand-usage decode helpers used by both the controller and its scoreboard.
package exec_issue_ctrl_pkg;

    localparam int REG_W    = 5;
    localparam int NUM_REGS = 32;
    localparam int TYPE_W   = 6;

    // Bit positions inside the one-hot {r,i,s,b,u,j} type field, r at MSB.
    localparam int TYPE_R = 5;
    localparam int TYPE_I = 4;
    localparam int TYPE_S = 3;
    localparam int TYPE_B = 2;
    localparam int TYPE_U = 1;
    localparam int TYPE_J = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    function automatic logic uses_rs1(input logic [TYPE_W-1:0] t);
        return t[TYPE_R] | t[TYPE_I] | t[TYPE_S] | t[TYPE_B];
    endfunction

    function automatic logic uses_rs2(input logic [TYPE_W-1:0] t);
        return t[TYPE_R] | t[TYPE_S] | t[TYPE_B];
    endfunction

    function automatic logic writes_rd(input logic [TYPE_W-1:0] t);
        return t[TYPE_R] | t[TYPE_I] | t[TYPE_U] | t[TYPE_J];
    endfunction

    // Branches and jumps are the only types whose taken outcome redirects fetch.
    function automatic logic is_ctrl_xfer(input logic [TYPE_W-1:0] t);
        return t[TYPE_B] | t[TYPE_J];
    endfunction

endpackage

// File: rtl/exec_issue_ctrl_if.sv
// Decode/execute/writeback handshake bundle for the issue controller.
// master = decode/execute/writeback side, slave = the controller.
interface exec_issue_ctrl_if;
    import exec_issue_ctrl_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [TYPE_W-1:0] in_type;
    logic [REG_W-1:0]  in_rd;
    logic [REG_W-1:0]  in_rs1;
    logic [REG_W-1:0]  in_rs2;
    logic              ex_valid;
    logic [TYPE_W-1:0] ex_type;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_done;
    logic              ex_taken;
    logic              wb_valid;
    logic [REG_W-1:0]  wb_rd;
    logic              flush;
    logic              err;

    modport master (
        output in_valid, in_type, in_rd, in_rs1, in_rs2,
        output ex_done, ex_taken, wb_valid, wb_rd,
        input  in_ready, ex_valid, ex_type, ex_rd, flush, err
    );

    modport slave (
        input  in_valid, in_type, in_rd, in_rs1, in_rs2,
        input  ex_done, ex_taken, wb_valid, wb_rd,
        output in_ready, ex_valid, ex_type, ex_rd, flush, err
    );

endinterface

// File: rtl/exec_issue_ctrl_scoreboard.sv
// Register busy scoreboard: one pending-write bit per architectural register.
// Writeback clears are bypassed into the hazard compare in the same cycle, and
// a set on issue wins over a same-cycle clear of the same index. Register 0 is
// never busy.
module exec_scoreboard
    import exec_issue_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [TYPE_W-1:0] chk_type,
    input  logic [REG_W-1:0]  chk_rs1,
    input  logic [REG_W-1:0]  chk_rs2,
    input  logic              set_en,
    input  logic [REG_W-1:0]  set_rd,
    input  logic              wb_valid,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic              clr_en,
    input  logic [REG_W-1:0]  clr_rd,
    output logic              hazard
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_byp;
    logic [NUM_REGS-1:0] busy_next;

    // Busy view with this cycle's writeback already retired.
    always_comb begin
        busy_byp = busy;
        if (wb_valid) busy_byp[wb_rd] = 1'b0;
    end

    assign hazard = (uses_rs1(chk_type) & busy_byp[chk_rs1]) |
                    (uses_rs2(chk_type) & busy_byp[chk_rs2]);

    // Apply clears first so that an issue-time set of the same index wins.
    always_comb begin
        busy_next = busy_byp;
        if (clr_en) busy_next[clr_rd] = 1'b0;
        if (set_en) busy_next[set_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy <= '0;
        else     busy <= busy_next;
    end

endmodule

// File: rtl/exec_issue_ctrl.sv
// Execute issue controller: accepts one decoded instruction at a time when its
// sources are free, pulses it to execute, waits for completion (with timeout),
// and emits a one-cycle flush for taken branches/jumps.
// Optional feature macro: EXEC_ISSUE_STALL_CNT_EN adds the stall_cnt output.
module exec_issue_ctrl
    import exec_issue_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 15
)(
    input  logic             clk,
    input  logic             rst,
    exec_issue_ctrl_if.slave bus
`ifdef EXEC_ISSUE_STALL_CNT_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    // Timeout fires on the MAX_WAIT-th WAIT cycle that sees no completion.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t            state;
    state_t            state_next;
    logic [7:0]        wait_cnt;
    logic              hazard;
    logic              accept;
    logic              timeout;
    logic              rd_set;
    logic [TYPE_W-1:0] ex_type_q;
    logic [REG_W-1:0]  ex_rd_q;
    logic              err_q;

    assign accept  = bus.in_valid & bus.in_ready;
    assign timeout = (state == ST_WAIT) & ~bus.ex_done & (wait_cnt == WAIT_LAST);
    assign rd_set  = accept & writes_rd(bus.in_type) & (bus.in_rd != '0);

    exec_scoreboard u_sb (
        .clk      (clk),
        .rst      (rst),
        .chk_type (bus.in_type),
        .chk_rs1  (bus.in_rs1),
        .chk_rs2  (bus.in_rs2),
        .set_en   (rd_set),
        .set_rd   (bus.in_rd),
        .wb_valid (bus.wb_valid),
        .wb_rd    (bus.wb_rd),
        .clr_en   (timeout),
        .clr_rd   (ex_rd_q),
        .hazard   (hazard)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Next-state logic; ex_done is only honoured while waiting.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (accept) state_next = ST_ISSUE;
            ST_ISSUE: state_next = ST_WAIT;
            ST_WAIT: begin
                if (bus.ex_done)
                    state_next = (bus.ex_taken & is_ctrl_xfer(ex_type_q)) ? ST_FLUSH : ST_IDLE;
                else if (timeout)
                    state_next = ST_IDLE;
            end
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Moore outputs: issue pulse in ISSUE, flush pulse in FLUSH, ready only in IDLE.
    always_comb begin
        bus.in_ready = 1'b0;
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        case (state)
            ST_IDLE:  bus.in_ready = ~hazard;
            ST_ISSUE: bus.ex_valid = 1'b1;
            ST_FLUSH: bus.flush    = 1'b1;
            default:  ;
        endcase
    end

    // Capture the accepted instruction's type and destination.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_type_q <= '0;
            ex_rd_q   <= '0;
        end else if (accept) begin
            ex_type_q <= bus.in_type;
            ex_rd_q   <= bus.in_rd;
        end
    end

    // WAIT cycle counter, held at zero outside WAIT so every entry starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wait_cnt <= '0;
        else if (state != ST_WAIT) wait_cnt <= '0;
        else                      wait_cnt <= wait_cnt + 8'd1;
    end

    // Sticky timeout flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (timeout) err_q <= 1'b1;
    end

    assign bus.ex_type = ex_type_q;
    assign bus.ex_rd   = ex_rd_q;
    assign bus.err     = err_q;

`ifdef EXEC_ISSUE_STALL_CNT_EN
    // Count cycles in which an offered instruction is held off.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                stall_cnt <= '0;
        else if (bus.in_valid & ~bus.in_ready)  stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_exec_issue_ctrl.sv
// Testbench for exec_issue_ctrl: directed scenarios followed by random traffic,
// checked against a behavioural model; issue and flush pulses are predicted into
// an event queue and matched by an independent monitor.
module tb_exec_issue_ctrl;

    localparam int MW = 4;

    localparam logic [5:0] T_R = 6'b100000;
    localparam logic [5:0] T_I = 6'b010000;
    localparam logic [5:0] T_S = 6'b001000;
    localparam logic [5:0] T_B = 6'b000100;
    localparam logic [5:0] T_U = 6'b000010;
    localparam logic [5:0] T_J = 6'b000001;

    logic clk = 1'b0;
    logic rst = 1'b1;

    exec_issue_ctrl_if bus();

`ifdef EXEC_ISSUE_STALL_CNT_EN
    logic [31:0] stall_cnt;
`endif

    exec_issue_ctrl #(.MAX_WAIT(MW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus)
`ifdef EXEC_ISSUE_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_flush;
        logic [5:0]  typ;
        logic [4:0]  rd;
        int unsigned due;
    } evt_t;

    evt_t evq[$];

    // Behavioural model state.
    bit          m_busy[32];
    int          m_phase;      // 0 idle, 1 just issued, 2 executing, 3 flushing
    int          m_waited;
    logic [5:0]  m_type;
    logic [4:0]  m_rd;
    bit          m_err;
    int unsigned m_stall;
    bit          last_ready;

    function automatic string kind(input logic [5:0] t);
        case (t)
            6'b100000: return "r";
            6'b010000: return "i";
            6'b001000: return "s";
            6'b000100: return "b";
            6'b000010: return "u";
            6'b000001: return "j";
            default:   return "?";
        endcase
    endfunction

    function automatic bit reads_rs1(input logic [5:0] t);
        string k = kind(t);
        return (k == "r") || (k == "i") || (k == "s") || (k == "b");
    endfunction

    function automatic bit reads_rs2(input logic [5:0] t);
        string k = kind(t);
        return (k == "r") || (k == "s") || (k == "b");
    endfunction

    function automatic bit has_dest(input logic [5:0] t);
        string k = kind(t);
        return (k == "r") || (k == "i") || (k == "u") || (k == "j");
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        m_phase  = 0;
        m_waited = 0;
        m_type   = '0;
        m_rd     = '0;
        m_err    = 1'b0;
        m_stall  = 0;
        evq.delete();
    endtask

    // One clock cycle: drive inputs, compare combinational/sticky outputs, then
    // advance the model to what the coming rising edge should produce.
    task automatic step(input bit v, input logic [5:0] t, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit done, input bit taken, input bit wv, input logic [4:0] wrd);
        bit byp[32];
        bit haz;
        bit exp_ready;
        @(negedge clk);
        bus.in_valid = v;
        bus.in_type  = t;
        bus.in_rd    = rd;
        bus.in_rs1   = rs1;
        bus.in_rs2   = rs2;
        bus.ex_done  = done;
        bus.ex_taken = taken;
        bus.wb_valid = wv;
        bus.wb_rd    = wrd;
        #1;
        byp = m_busy;
        if (wv) byp[wrd] = 1'b0;
        haz = (reads_rs1(t) && byp[rs1]) || (reads_rs2(t) && byp[rs2]);
        exp_ready = (m_phase == 0) && !haz;
        last_ready = bus.in_ready;
        check("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_ready});
        check("err", {31'd0, bus.err}, {31'd0, m_err});
`ifdef EXEC_ISSUE_STALL_CNT_EN
        check("stall_cnt", stall_cnt, m_stall);
`endif
        if (!rst) begin
            if (v && !exp_ready) m_stall++;
            if (wv) m_busy[wrd] = 1'b0;
            case (m_phase)
                0: if (v && exp_ready) begin
                    m_type = t;
                    m_rd   = rd;
                    if (has_dest(t) && rd != 0) m_busy[rd] = 1'b1;
                    evq.push_back('{1'b0, t, rd, cyc + 1});
                    m_phase = 1;
                end
                1: begin
                    m_phase  = 2;
                    m_waited = 0;
                end
                2: if (done) begin
                    if (taken && (kind(m_type) == "b" || kind(m_type) == "j")) begin
                        m_phase = 3;
                        evq.push_back('{1'b1, 6'd0, 5'd0, cyc + 1});
                    end else begin
                        m_phase = 0;
                    end
                end else begin
                    m_waited++;
                    if (m_waited == MW) begin
                        m_err = 1'b1;
                        m_busy[m_rd] = 1'b0;
                        m_phase = 0;
                    end
                end
                default: m_phase = 0;
            endcase
            m_busy[0] = 1'b0;
        end
    endtask

    task automatic idle(input bit done = 1'b0, input bit taken = 1'b0);
        step(1'b0, T_R, 5'd0, 5'd0, 5'd0, done, taken, 1'b0, 5'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_ex_valid", {31'd0, bus.ex_valid}, 32'd0);
        check("rst_flush",    {31'd0, bus.flush},    32'd0);
        check("rst_err",      {31'd0, bus.err},      32'd0);
        check("rst_ex_type",  {26'd0, bus.ex_type},  32'd0);
        check("rst_ex_rd",    {27'd0, bus.ex_rd},    32'd0);
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef EXEC_ISSUE_STALL_CNT_EN
        check("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset_async();
        @(posedge clk);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_outputs();
        idle();
        rst = 1'b0;
    endtask

    // Monitor: every issue or flush pulse must match the head of the event queue.
    always @(negedge clk) begin
        evt_t e;
        #1;
        check("ex_valid_flush_exclusive", {31'd0, bus.ex_valid & bus.flush}, 32'd0);
        if (bus.ex_valid || bus.flush) begin
            if (evq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse ex_valid=%0b flush=%0b expected none at cycle %0d",
                         bus.ex_valid, bus.flush, cyc);
            end else begin
                e = evq.pop_front();
                check("pulse_kind_flush", {31'd0, bus.flush}, {31'd0, e.is_flush});
                check("pulse_cycle", cyc, e.due);
                if (!e.is_flush) begin
                    check("ex_type", {26'd0, bus.ex_type}, {26'd0, e.typ});
                    check("ex_rd",   {27'd0, bus.ex_rd},   {27'd0, e.rd});
                end
            end
        end else if (evq.size() > 0 && evq[0].due <= cyc) begin
            e = evq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse flush=%0b due_cycle=%0d seen none at cycle %0d",
                     e.is_flush, e.due, cyc);
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_type  = '0;
        bus.in_rd    = '0;
        bus.in_rs1   = '0;
        bus.in_rs2   = '0;
        bus.ex_done  = 1'b0;
        bus.ex_taken = 1'b0;
        bus.wb_valid = 1'b0;
        bus.wb_rd    = '0;
        rst = 1'b1;
        model_reset();

        // Power-on reset.
        idle();
        check_reset_outputs();
        idle();
        rst = 1'b0;

        // r rd=5 issues, pulses next cycle; ex_done during ISSUE is ignored.
        step(1'b1, T_R, 5'd5, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        // i rs1=5 stalls on busy[5]; same-cycle writeback of 5 releases it.
        step(1'b1, T_I, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("busy5_stalls", {31'd0, last_ready}, 32'd0);
        step(1'b1, T_I, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        check("wb_bypass_ready", {31'd0, last_ready}, 32'd1);
        idle();
        idle(1'b1, 1'b1);   // taken on an i-type: no flush
        step(1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd6);

        // Taken branch: one-cycle flush then ready again.
        step(1'b1, T_B, 5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        idle(1'b1, 1'b1);
        step(1'b1, T_I, 5'd2, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("flush_blocks_ready", {31'd0, last_ready}, 32'd0);
        idle();
        check("ready_after_flush", {31'd0, last_ready}, 32'd1);

        // Taken jump with a destination.
        step(1'b1, T_J, 5'd4, 5'd9, 5'd9, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        idle(1'b1, 1'b1);
        step(1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4);

        // i rd=0 leaves nothing busy; rs1=0 never stalls.
        step(1'b1, T_I, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        idle(1'b1, 1'b0);
        step(1'b1, T_S, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("rd0_no_stall", {31'd0, last_ready}, 32'd1);
        idle();
        idle(1'b1, 1'b0);

        // Timeout: r rd=7 never completes.
        step(1'b1, T_R, 5'd7, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        for (int i = 0; i < MW; i++) idle();
        idle();
        check("timeout_err", {31'd0, bus.err}, 32'd1);
        step(1'b1, T_U, 5'd8, 5'd7, 5'd7, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        idle(1'b1, 1'b0);
        step(1'b1, T_I, 5'd1, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
        check("timeout_cleared_busy7", {31'd0, last_ready}, 32'd1);
        idle();
        idle(1'b1, 1'b0);

        // Hold a hazard on busy[8] for three cycles, then clear it.
        for (int i = 0; i < 3; i++)
            step(1'b1, T_S, 5'd0, 5'd1, 5'd8, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, T_R, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd8);

        // Reset while waiting (err is still set from the timeout).
        step(1'b1, T_B, 5'd0, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0);
        idle();
        idle();
        do_reset_async();
        idle(1'b1, 1'b1);
        idle();

        // Random traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 350) begin
                do_reset_async();
            end else begin
                step($urandom_range(0, 3) != 0,
                     6'd1 << $urandom_range(0, 5),
                     5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)),
                     $urandom_range(0, 2) == 0,
                     $urandom_range(0, 1) == 1,
                     $urandom_range(0, 3) == 0,
                     5'($urandom_range(0, 7)));
            end
        end

        for (int i = 0; i < MW + 4; i++) idle(1'b1, 1'b0);
        check("event_queue_drained", evq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
